fir_mac_sched: RTL and testbench
================================

// Module: fir_mac_sched
// PURPOSE
//  Sequencer for the time-multiplexed FIR datapath: one multiplier + accumulating adder
//  shared across all taps. Per input sample strobe it writes the sample into a circular
//  delay line, steps TAPS coefficient/sample read addresses, drives accumulator clear/enable
//  aligned to the multiply and adder pipeline latencies, and presents out_valid/out_ready.
// PARAMETERS
//  TAPS     8  number of filter taps (>=2, power of two)
//  AW       3  address width, = clog2(TAPS)
//  MUL_LAT  1  multiplier pipeline latency in cycles (>=1)
//  ADD_LAT  1  adder/accumulator register latency in cycles (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, synchronous, active-low
//  samp_stb   in   1   new input sample present this cycle (no backpressure)
//  busy       out  1   sample strobe this cycle will be dropped
//  wr_en      out  1   write delay line at wr_addr
//  wr_addr    out  AW  delay-line write address (= wr_ptr)
//  rd_addr    out  AW  delay-line read address for current tap
//  coef_addr  out  AW  coefficient ROM address for current tap
//  acc_clr    out  1   accumulator loads product instead of adding
//  acc_en     out  1   accumulator update enable
//  out_valid  out  1   accumulator holds finished result
//  out_ready  in   1   downstream accepts result
//  drop_cnt   out  8   dropped-sample count (FIR_SCHED_DROP_CNT_EN only)
// BEHAVIOUR
//  Reset (rst=0 at edge): state IDLE, wr_ptr=0, tap k=0, drain cnt=0; all outputs 0; any
//   in-flight result discarded, no out_valid afterwards.
//  FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE (or -> RUN on back-to-back accept).
//  IDLE: busy=0. samp_stb=1 -> wr_en=1 for that cycle, wr_addr=wr_ptr; next RUN, k=0.
//  RUN (TAPS cycles, k=0..TAPS-1): coef_addr=k; rd_addr=(wr_ptr-k) mod TAPS (newest first,
//   wraps modulo TAPS); after k=TAPS-1 -> DRAIN.
//  acc_en = issue-valid delayed MUL_LAT cycles; acc_clr = (k==0) delayed MUL_LAT, coincident
//   with first acc_en. acc_clr never asserted without acc_en.
//  DRAIN: MUL_LAT+ADD_LAT-1 cycles (counter), then DONE.
//  DONE: out_valid=1, held until out_ready=1. On handshake wr_ptr<=(wr_ptr+1) mod TAPS.
//  Latency: acceptance cycle 0 -> out_valid first high at cycle TAPS+MUL_LAT+ADD_LAT
//   (10 with defaults). Throughput max 1 sample per TAPS+MUL_LAT+ADD_LAT cycles.
//  busy = (state!=IDLE) && !(state==DONE && out_ready). Same-cycle DONE handshake + samp_stb:
//   sample accepted, wr_en=1 at wr_ptr+1 (incremented ptr), next state RUN.
//  samp_stb while busy=1: sample dropped, no wr_en, FSM unaffected.
//  out_valid stalled indefinitely by out_ready=0: addresses frozen, acc_en=0.
//  All outputs registered except busy and wr_addr/wr_en in DONE back-to-back case.
// CONFIGURATION
//  FIR_SCHED_DROP_CNT_EN defined: drop_cnt increments on each samp_stb&&busy, saturates at
//   255, cleared only by reset. Undefined: drop_cnt tied to 0, no counter logic.
// TESTING
//  1 rst=0 3 cycles, release -> all outputs 0, busy=0, wr_addr=0, drop_cnt=0.
//  2 single samp_stb in IDLE, out_ready=1 -> wr_en@c0 addr0; rd_addr 0,7,6,...,1 @c1..c8;
//    acc_en c2..c9, acc_clr c2 only; out_valid c10 one cycle; next wr_addr=1.
//  3 nine samples back-to-back-accepted -> wr_ptr wraps 7->0; rd sequence after wrap 0,7,..,1.
//  4 out_ready=0 for 5 cycles in DONE -> out_valid held, acc_en=0, busy=1; samp_stb there
//    dropped (no wr_en); with DROP_CNT_EN drop_cnt=1; 300 drops -> drop_cnt=255.
//  5 out_ready=1 & samp_stb same DONE cycle -> wr_en same cycle, RUN next, no IDLE gap.
//  6 rst=0 mid-RUN at k=4 -> next cycle IDLE, acc_en/out_valid 0, no result emitted, wr_ptr=0.

Source files
------------

// File: rtl/fir_mac_sched.sv
// ---------------------------------------------------------------------------
// fir_mac_sched
//
// Sequencer for a time-multiplexed FIR datapath: a single multiplier and an
// accumulating adder are shared across all taps. For each accepted input
// sample the block writes the sample into a circular delay line, then walks
// TAPS coefficient/sample read addresses (newest sample first). It drives the
// accumulator clear/enable so they line up with the multiplier and adder
// pipeline latencies, and holds out_valid until downstream accepts.
//
// Parameters
//   TAPS     number of filter taps (>=2, power of two)
//   AW       address width, = clog2(TAPS)
//   MUL_LAT  multiplier pipeline latency in cycles (>=1)
//   ADD_LAT  adder/accumulator register latency in cycles (>=1)
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous reset, active low
//   samp_stb   in   1   new input sample present this cycle (no backpressure)
//   busy       out  1   a sample strobe this cycle will be dropped
//   wr_en      out  1   write delay line at wr_addr
//   wr_addr    out  AW  delay-line write address
//   rd_addr    out  AW  delay-line read address for current tap
//   coef_addr  out  AW  coefficient ROM address for current tap
//   acc_clr    out  1   accumulator loads product instead of adding
//   acc_en     out  1   accumulator update enable
//   out_valid  out  1   accumulator holds a finished result
//   out_ready  in   1   downstream accepts the result
//   drop_cnt   out  8   saturating count of dropped samples
//
// Configuration
//   FIR_SCHED_DROP_CNT_EN  when defined, drop_cnt counts samp_stb && busy and
//                          saturates at 255 (cleared only by reset). When it
//                          is undefined, drop_cnt is tied to zero.
// ---------------------------------------------------------------------------
module fir_mac_sched #(
    parameter int TAPS    = 8,
    parameter int AW      = 3,
    parameter int MUL_LAT = 1,
    parameter int ADD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          samp_stb,
    output logic          busy,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] coef_addr,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    drop_cnt
);

    // The last product leaves the multiplier MUL_LAT cycles after its issue
    // and lands in the accumulator ADD_LAT cycles later. One of those cycles
    // overlaps the final RUN cycle, which leaves this many DRAIN cycles.
    localparam int DRAIN_CYC = MUL_LAT + ADD_LAT - 1;
    localparam int DCW       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q,     state_d;
    logic [AW-1:0]        wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]        k_q,         k_d;
    logic [DCW-1:0]       drain_q,     drain_d;
    logic [AW-1:0]        rd_addr_q,   rd_addr_d;
    logic [AW-1:0]        coef_addr_q, coef_addr_d;
    logic [MUL_LAT-1:0]   en_pipe_q,   en_pipe_d;
    logic [MUL_LAT-1:0]   clr_pipe_q,  clr_pipe_d;
    logic                 out_valid_q, out_valid_d;

    logic                 handshake;
    logic [AW-1:0]        wr_ptr_inc;

    assign handshake  = (state_q == DONE) && out_ready;
    assign wr_ptr_inc = wr_ptr_q + AW'(1);

    // State register: every flop of the sequencer lives here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            k_q         <= '0;
            drain_q     <= '0;
            rd_addr_q   <= '0;
            coef_addr_q <= '0;
            en_pipe_q   <= '0;
            clr_pipe_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            k_q         <= k_d;
            drain_q     <= drain_d;
            rd_addr_q   <= rd_addr_d;
            coef_addr_q <= coef_addr_d;
            en_pipe_q   <= en_pipe_d;
            clr_pipe_q  <= clr_pipe_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic. wr_ptr points at the newest sample while the taps are
    // walked. It advances only on the result handshake, so a back-to-back
    // sample is written at the incremented pointer.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        k_d      = k_q;
        drain_d  = drain_q;
        case (state_q)
            IDLE: begin
                if (samp_stb) begin
                    state_d = RUN;
                    k_d     = '0;
                end
            end
            RUN: begin
                if (k_q == AW'(TAPS - 1)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DCW'(DRAIN_CYC - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    wr_ptr_d = wr_ptr_inc;
                    k_d      = '0;
                    state_d  = samp_stb ? RUN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic. The registered outputs are computed from the next-state
    // values, so they change on the same edge as the state. Addresses hold
    // their last value outside RUN, which keeps them frozen during a stall.
    always_comb begin
        rd_addr_d   = rd_addr_q;
        coef_addr_d = coef_addr_q;
        if (state_d == RUN) begin
            rd_addr_d   = wr_ptr_d - k_d;
            coef_addr_d = k_d;
        end

        // Each issue cycle travels down a MUL_LAT-deep pipe, so acc_en and
        // acc_clr appear exactly when the matching product leaves the
        // multiplier. clr is only ever set on an issue cycle, so it cannot
        // show up without en.
        en_pipe_d     = '0;
        clr_pipe_d    = '0;
        en_pipe_d[0]  = (state_q == RUN);
        clr_pipe_d[0] = (state_q == RUN) && (k_q == '0);
        for (int i = 1; i < MUL_LAT; i++) begin
            en_pipe_d[i]  = en_pipe_q[i-1];
            clr_pipe_d[i] = clr_pipe_q[i-1];
        end

        out_valid_d = (state_d == DONE);
    end

    // busy, wr_en and wr_addr are combinational. A sample strobe that
    // coincides with the DONE handshake must be written in that same cycle.
    // It goes to the slot after the current pointer.
    assign busy      = (state_q != IDLE) && !handshake;
    assign wr_en     = rst && samp_stb && !busy;
    assign wr_addr   = handshake ? wr_ptr_inc : wr_ptr_q;

    assign rd_addr   = rd_addr_q;
    assign coef_addr = coef_addr_q;
    assign acc_en    = en_pipe_q[MUL_LAT-1];
    assign acc_clr   = clr_pipe_q[MUL_LAT-1];
    assign out_valid = out_valid_q;

`ifdef FIR_SCHED_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating counter of samples lost while the sequencer was busy.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (samp_stb && busy && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fir_mac_sched.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_sched
//
// Directed testbench for fir_mac_sched with the default parameters
// (TAPS=8, MUL_LAT=1, ADD_LAT=1). Inputs change 2 ns after each rising edge.
// Outputs are sampled 1 ns after that.
// ---------------------------------------------------------------------------
module tb_fir_mac_sched;

    localparam int TAPS = 8;
    localparam int AW   = 3;

`ifdef FIR_SCHED_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          samp_stb = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] coef_addr;
    logic          acc_clr;
    logic          acc_en;
    logic          out_valid;
    logic [7:0]    drop_cnt;

    int checks = 0;
    int errors = 0;

    fir_mac_sched #(
        .TAPS    (TAPS),
        .AW      (AW),
        .MUL_LAT (1),
        .ADD_LAT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .samp_stb  (samp_stb),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .coef_addr (coef_addr),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Advance to 2 ns past the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        samp_stb = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({busy, wr_en, acc_clr, acc_en, out_valid} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b expected 00000", {busy, wr_en, acc_clr, acc_en, out_valid});
        end
        checks++;
        if ({wr_addr, rd_addr, coef_addr} !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_addr got %h/%h/%h expected 0/0/0", wr_addr, rd_addr, coef_addr);
        end
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_drop got %0d expected 0", drop_cnt);
        end
    endtask

    task automatic test_single();
        logic [AW-1:0] exp_rd;
        out_ready = 1'b1;
        samp_stb = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_accept got wr_en=%b addr=%0d busy=%b expected 1/0/0", wr_en, wr_addr, busy);
        end
        step();
        samp_stb = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            #1;
            if (c <= 8) begin
                exp_rd = 3'((TAPS - (c - 1)) % TAPS);
                checks++;
                if (rd_addr !== exp_rd || coef_addr !== 3'(c - 1)) begin
                    errors++;
                    $display("[TB] FAIL single_addr c%0d got rd=%0d coef=%0d expected rd=%0d coef=%0d", c, rd_addr, coef_addr, exp_rd, c - 1);
                end
            end
            checks++;
            if (acc_en !== 1'((c >= 2) && (c <= 9)) || acc_clr !== 1'(c == 2)) begin
                errors++;
                $display("[TB] FAIL single_acc c%0d got en=%b clr=%b expected en=%b clr=%b", c, acc_en, acc_clr, (c >= 2) && (c <= 9), c == 2);
            end
            checks++;
            if (out_valid !== 1'(c == 10) || busy !== 1'(c <= 9)) begin
                errors++;
                $display("[TB] FAIL single_valid c%0d got valid=%b busy=%b expected valid=%b busy=%b", c, out_valid, busy, c == 10, c <= 9);
            end
            if (c == 11) begin
                checks++;
                if (wr_addr !== 3'd1) begin
                    errors++;
                    $display("[TB] FAIL single_next_ptr got %0d expected 1", wr_addr);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_rd;
        int bad;
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            samp_stb = 1'b1;
            #1;
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 3'(n % TAPS) || out_valid !== 1'(n > 0)) begin
                errors++;
                $display("[TB] FAIL b2b_accept n%0d got wr_en=%b addr=%0d valid=%b expected 1/%0d/%b", n, wr_en, wr_addr, out_valid, n % TAPS, n > 0);
            end
            step();
            samp_stb = 1'b0;
            bad = 0;
            for (int k = 0; k < TAPS; k++) begin
                #1;
                exp_rd = 3'((n % TAPS - k + TAPS) % TAPS);
                if (rd_addr !== exp_rd) bad++;
                step();
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL b2b_rd_seq n%0d got %0d wrong addresses expected 0", n, bad);
            end
            step();
        end
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_last_valid got %b expected 1", out_valid);
        end
        step();
        #1;
        checks++;
        if (busy !== 1'b0 || wr_addr !== 3'd1) begin
            errors++;
            $display("[TB] FAIL b2b_end got busy=%b addr=%0d expected 0/1", busy, wr_addr);
        end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        samp_stb = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_accept got %b expected 1", wr_en);
        end
        step();
        samp_stb = 1'b0;
        repeat (9) step();
        for (int i = 0; i < 5; i++) begin
            samp_stb = (i == 2);
            #1;
            checks++;
            if (out_valid !== 1'b1 || acc_en !== 1'b0 || busy !== 1'b1 || wr_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold i%0d got valid=%b en=%b busy=%b wr_en=%b expected 1/0/1/0", i, out_valid, acc_en, busy, wr_en);
            end
            checks++;
            if (rd_addr !== 3'd1 || coef_addr !== 3'd7) begin
                errors++;
                $display("[TB] FAIL stall_frozen i%0d got rd=%0d coef=%0d expected 1/7", i, rd_addr, coef_addr);
            end
            step();
        end
        samp_stb = 1'b0;
        #1;
        checks++;
        if (drop_cnt !== 8'(DROP_EN ? 1 : 0)) begin
            errors++;
            $display("[TB] FAIL drop_one got %0d expected %0d", drop_cnt, DROP_EN ? 1 : 0);
        end
        samp_stb = 1'b1;
        repeat (300) step();
        samp_stb = 1'b0;
        #1;
        checks++;
        if (drop_cnt !== 8'(DROP_EN ? 255 : 0) || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drop_sat got cnt=%0d valid=%b expected %0d/1", drop_cnt, out_valid, DROP_EN ? 255 : 0);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_release_busy got %b expected 0", busy);
        end
        step();
        #1;
        checks++;
        if (out_valid !== 1'b0 || wr_addr !== 3'd1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_after got valid=%b addr=%0d busy=%b expected 0/1/0", out_valid, wr_addr, busy);
        end
    endtask

    task automatic test_done_accept();
        out_ready = 1'b0;
        samp_stb = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 3'd1) begin
            errors++;
            $display("[TB] FAIL done_first got wr_en=%b addr=%0d expected 1/1", wr_en, wr_addr);
        end
        step();
        samp_stb = 1'b0;
        repeat (9) step();
        out_ready = 1'b1;
        samp_stb = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 3'd2 || busy !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_same_cycle got wr_en=%b addr=%0d busy=%b valid=%b expected 1/2/0/1", wr_en, wr_addr, busy, out_valid);
        end
        step();
        samp_stb = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || rd_addr !== 3'd2 || coef_addr !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_no_gap got busy=%b rd=%0d coef=%0d valid=%b expected 1/2/0/0", busy, rd_addr, coef_addr, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        repeat (4) step();
        #1;
        checks++;
        if (rd_addr !== 3'd6 || coef_addr !== 3'd4) begin
            errors++;
            $display("[TB] FAIL midrun_pos got rd=%0d coef=%0d expected 6/4", rd_addr, coef_addr);
        end
        rst = 1'b0;
        step();
        #1;
        checks++;
        if ({acc_en, acc_clr, out_valid, busy} !== 4'b0 || wr_addr !== 3'd0 || rd_addr !== 3'd0) begin
            errors++;
            $display("[TB] FAIL midrun_reset got ctrl=%b wr=%0d rd=%0d expected 0000/0/0", {acc_en, acc_clr, out_valid, busy}, wr_addr, rd_addr);
        end
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid !== 1'b0 || acc_en !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL midrun_no_result got %0d active cycles expected 0", seen);
        end
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL midrun_drop got %0d expected 0", drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_done_accept();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
